// File: rtl/scale_pkg.sv
// Shared types and constants for the scale-path rate bridge.
// Pixel layout, divider limits and FIFO pointer sizing helpers.
package scale_pkg;

   localparam int CLK_DIV_MIN = 1;
   localparam int CLK_DIV_MAX = 8;
   localparam int PIX_W       = 24;

   typedef struct packed {
      logic             last;
      logic [PIX_W-1:0] data;
   } pixel_t;

   // One extra bit beyond the address distinguishes full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/scale_rate_bridge_if.sv
// Pixel stream in and out of the rate bridge; slave is the bridge side.
interface scale_rate_bridge_if #(parameter int DATA_W = 24);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport slave  (input  in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_data, out_last);
   modport master (output in_valid, in_data, in_last, out_ready,
                   input  in_ready, out_valid, out_data, out_last);

endinterface

// File: rtl/scale_ce_gen.sv
// Free-running divide-by-CLK_DIVIDER clock-enable strobe, restartable by flush.
module scale_ce_gen
   import scale_pkg::*;
#(
   parameter int CLK_DIVIDER = 1
) (
   input  logic pclk,
   input  logic rst_n,
   input  logic flush,
   output logic ce_out
);

   localparam int            CW   = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIVIDER - 1);

   logic [CW-1:0] cnt, cnt_nxt;

   always_comb begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
      if (flush) cnt_nxt = '0;
   end

   // Strobe is registered from the next count so it lines up with cnt == LAST.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         ce_out <= (CLK_DIVIDER == CLK_DIV_MIN);
      end else begin
         cnt    <= cnt_nxt;
         ce_out <= (cnt_nxt == LAST);
      end
   end

endmodule

// File: rtl/scale_rate_bridge.sv
// Buffers a pclk pixel stream and releases at most one pixel per ce_out strobe
// so the scale module runs at 1/CLK_DIVIDER rate without a divided clock.
module scale_rate_bridge
   import scale_pkg::*;
#(
   parameter int CLK_DIVIDER = 1,
   parameter int DATA_W      = 24,
   parameter int DEPTH       = 4
) (
   input  logic                          pclk,
   input  logic                          rst_n,
   input  logic                          flush,
   scale_rate_bridge_if.slave            bus,
   output logic                          ce_out,
   output logic [ptr_width(DEPTH)-1:0]   level
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   if (CLK_DIVIDER < CLK_DIV_MIN || CLK_DIVIDER > CLK_DIV_MAX) begin : g_bad_div
      $error("scale_rate_bridge: CLK_DIVIDER must be within 1..8");
   end
   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("scale_rate_bridge: DEPTH must be a power of two, at least 2");
   end

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          full, empty, push, pop;

   scale_ce_gen #(.CLK_DIVIDER(CLK_DIVIDER)) u_ce (
      .pclk   (pclk),
      .rst_n  (rst_n),
      .flush  (flush),
      .ce_out (ce_out)
   );

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // No bypass: a full FIFO refuses input even when the head leaves this cycle.
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign push          = bus.in_valid && !full && !flush;
   assign pop           = ce_out && !empty && bus.out_ready;

   assign bus.out_data  = mem[rd_ptr[AW-1:0]].data;
   assign bus.out_last  = mem[rd_ptr[AW-1:0]].last;
   assign level         = wr_ptr - rd_ptr;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is cleared only by reset so the head reads zero afterwards; flush leaves it.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr[AW-1:0]] <= '{last: bus.in_last, data: bus.in_data};
      end
   end

   a_no_pop_empty: assert property (@(posedge pclk) disable iff (!rst_n) !(pop && empty));
   a_no_push_full: assert property (@(posedge pclk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_scale_rate_bridge.sv
// Bench for scale_rate_bridge: three instances (divide by 4, 1, 3) checked
// cycle by cycle against a queue-based model of the FIFO and strobe period.
module tb_scale_rate_bridge;
   import scale_pkg::*;

   localparam int DEPTH = 4;

   logic pclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   // sel picks which instance the driver and the observed signals refer to.
   int          sel = 0;
   logic        d_valid = 1'b0, d_last = 1'b0, d_ordy = 1'b0, d_flush = 1'b0;
   logic [23:0] d_data = '0;

   scale_rate_bridge_if #(.DATA_W(24)) b4();
   scale_rate_bridge_if #(.DATA_W(24)) b1();
   scale_rate_bridge_if #(.DATA_W(24)) b3();

   logic       fl4, fl1, fl3, ce4, ce1, ce3;
   logic [2:0] lv4, lv1, lv3;

   assign fl4 = (sel == 0) && d_flush;
   assign fl1 = (sel == 1) && d_flush;
   assign fl3 = (sel == 2) && d_flush;

   assign b4.in_valid = (sel == 0) && d_valid;
   assign b4.in_data = d_data;
   assign b4.in_last = d_last;
   assign b4.out_ready = (sel == 0) && d_ordy;
   assign b1.in_valid = (sel == 1) && d_valid;
   assign b1.in_data = d_data;
   assign b1.in_last = d_last;
   assign b1.out_ready = (sel == 1) && d_ordy;
   assign b3.in_valid = (sel == 2) && d_valid;
   assign b3.in_data = d_data;
   assign b3.in_last = d_last;
   assign b3.out_ready = (sel == 2) && d_ordy;

   scale_rate_bridge #(.CLK_DIVIDER(4), .DATA_W(24), .DEPTH(DEPTH)) u4 (
      .pclk(pclk), .rst_n(rst_n), .flush(fl4), .bus(b4), .ce_out(ce4), .level(lv4));
   scale_rate_bridge #(.CLK_DIVIDER(1), .DATA_W(24), .DEPTH(DEPTH)) u1 (
      .pclk(pclk), .rst_n(rst_n), .flush(fl1), .bus(b1), .ce_out(ce1), .level(lv1));
   scale_rate_bridge #(.CLK_DIVIDER(3), .DATA_W(24), .DEPTH(DEPTH)) u3 (
      .pclk(pclk), .rst_n(rst_n), .flush(fl3), .bus(b3), .ce_out(ce3), .level(lv3));

   logic        o_rdy, o_vld, o_last, o_ce;
   logic [23:0] o_data;
   logic [2:0]  o_lvl;

   always_comb begin
      o_rdy = b4.in_ready; o_vld = b4.out_valid; o_last = b4.out_last;
      o_data = b4.out_data; o_ce = ce4; o_lvl = lv4;
      if (sel == 1) begin
         o_rdy = b1.in_ready; o_vld = b1.out_valid; o_last = b1.out_last;
         o_data = b1.out_data; o_ce = ce1; o_lvl = lv1;
      end else if (sel == 2) begin
         o_rdy = b3.in_ready; o_vld = b3.out_valid; o_last = b3.out_last;
         o_data = b3.out_data; o_ce = ce3; o_lvl = lv3;
      end
   end

   // Reference model: pixel queue, cycles since reset/flush, and a log of pops.
   pixel_t mq[$];
   pixel_t popped[$];
   int     pop_ph[$];
   int     ph = 0;
   int     div = 4;

   function automatic int div_of(input int s);
      return (s == 1) ? 1 : (s == 2) ? 3 : 4;
   endfunction

   function automatic logic exp_ce();
      return logic'((ph % div) == (div - 1));
   endfunction

   // Drive one cycle of inputs, advance the model over the edge, land on next negedge.
   task automatic step(input logic v, input logic [23:0] d, input logic l,
                       input logic r, input logic f);
      logic ce;
      int   n;
      ce = exp_ce();
      n  = mq.size();
      d_valid = v; d_data = d; d_last = l; d_ordy = r; d_flush = f;
      if (f) begin
         mq.delete();
         ph = 0;
      end else begin
         if (ce && n > 0 && r) begin
            popped.push_back(mq.pop_front());
            pop_ph.push_back(ph);
         end
         if (v && n < DEPTH) mq.push_back('{last: l, data: d});
         ph++;
      end
      @(negedge pclk);
   endtask

   task automatic begin_test(input int s);
      sel = s;
      div = div_of(s);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      popped.delete();
      pop_ph.delete();
   endtask

   task automatic test_reset();
      @(negedge pclk);
      rst_n = 1'b1;
      mq.delete();
      ph = 0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (ce4 !== logic'(i % 4 == 3)) begin
            errors++; $display("FAIL reset_ce4 cyc=%0d got=%b want=%b", i, ce4, i % 4 == 3);
         end
         checks++;
         if (ce1 !== 1'b1) begin
            errors++; $display("FAIL reset_ce1 cyc=%0d got=%b want=1", i, ce1);
         end
         checks++;
         if (ce3 !== logic'(i % 3 == 2)) begin
            errors++; $display("FAIL reset_ce3 cyc=%0d got=%b want=%b", i, ce3, i % 3 == 2);
         end
         checks++;
         if (b4.out_valid !== 1'b0 || lv4 !== 3'd0 || b4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got vld=%b lvl=%0d rdy=%b want 0/0/1",
                     i, b4.out_valid, lv4, b4.in_ready);
         end
         if (i == 0) begin
            checks++;
            if (b4.out_data !== 24'd0 || b4.out_last !== 1'b0) begin
               errors++;
               $display("FAIL reset_head got=%h/%b want=000000/0", b4.out_data, b4.out_last);
            end
         end
         @(negedge pclk);
      end
   endtask

   task automatic test_burst();
      int sent;
      begin_test(0);
      sent = 0;
      for (int c = 0; c < 80 && popped.size() < 8; c++) begin
         checks++;
         if (o_ce !== exp_ce()) begin
            errors++; $display("FAIL burst_ce ph=%0d got=%b want=%b", ph, o_ce, exp_ce());
         end
         checks++;
         if (o_rdy !== logic'(mq.size() < DEPTH) || o_lvl !== 3'(mq.size())) begin
            errors++;
            $display("FAIL burst_rdy_lvl ph=%0d got rdy=%b lvl=%0d want rdy=%b lvl=%0d",
                     ph, o_rdy, o_lvl, mq.size() < DEPTH, mq.size());
         end
         if (mq.size() > 0) begin
            checks++;
            if (o_data !== mq[0].data || o_last !== mq[0].last) begin
               errors++;
               $display("FAIL burst_head ph=%0d got=%h/%b want=%h/%b",
                        ph, o_data, o_last, mq[0].data, mq[0].last);
            end
         end
         if (sent < 8 && mq.size() < DEPTH) begin
            step(1'b1, 24'(16 + sent), logic'(sent == 7), 1'b1, 1'b0);
            sent++;
         end else begin
            step(logic'(sent < 8), 24'(16 + sent), logic'(sent == 7), 1'b1, 1'b0);
         end
      end
      checks++;
      if (popped.size() != 8) begin
         errors++; $display("FAIL burst_count got=%0d want=8", popped.size());
      end
      for (int i = 0; i < popped.size(); i++) begin
         checks++;
         if (popped[i].data !== 24'(16 + i) || popped[i].last !== logic'(i == 7)
             || pop_ph[i] != 4 * i + 3) begin
            errors++;
            $display("FAIL burst_order idx=%0d got=%h/%b@%0d want=%h/%b@%0d", i,
                     popped[i].data, popped[i].last, pop_ph[i], 16 + i, i == 7, 4 * i + 3);
         end
      end
   endtask

   task automatic test_div1();
      logic [23:0] sent [12];
      begin_test(1);
      for (int i = 0; i < 12; i++) sent[i] = 24'($urandom);
      for (int c = 0; c < 13; c++) begin
         checks++;
         if (o_ce !== 1'b1 || o_lvl > 3'd1 || o_lvl !== 3'(mq.size())) begin
            errors++;
            $display("FAIL div1_rate c=%0d got ce=%b lvl=%0d want ce=1 lvl=%0d",
                     c, o_ce, o_lvl, mq.size());
         end
         if (mq.size() > 0) begin
            checks++;
            if (o_data !== mq[0].data) begin
               errors++; $display("FAIL div1_head c=%0d got=%h want=%h", c, o_data, mq[0].data);
            end
         end
         step(logic'(c < 12), (c < 12) ? sent[c] : 24'd0, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (popped.size() != 12) begin
         errors++; $display("FAIL div1_count got=%0d want=12", popped.size());
      end
      for (int i = 0; i < popped.size(); i++) begin
         checks++;
         if (popped[i].data !== sent[i] || pop_ph[i] != i + 1) begin
            errors++;
            $display("FAIL div1_latency idx=%0d got=%h@%0d want=%h@%0d",
                     i, popped[i].data, pop_ph[i], sent[i], i + 1);
         end
      end
   endtask

   task automatic test_hold();
      logic [23:0] a, b;
      begin_test(2);
      a = 24'($urandom);
      b = 24'($urandom);
      for (int c = 0; c < 10; c++) begin
         if (c >= 2) begin
            checks++;
            if (o_data !== ((c <= 8) ? a : b) || o_lvl !== 3'((c <= 8) ? 2 : 1)) begin
               errors++;
               $display("FAIL hold_head c=%0d got=%h lvl=%0d want=%h lvl=%0d",
                        c, o_data, o_lvl, (c <= 8) ? a : b, (c <= 8) ? 2 : 1);
            end
         end
         step(logic'(c < 2), (c == 0) ? a : b, 1'b0, logic'(c >= 7), 1'b0);
      end
      checks++;
      if (popped.size() != 1 || pop_ph[0] != 8 || popped[0].data !== a) begin
         errors++; $display("FAIL hold_pop got=%0d pops want=1 at ph 8", popped.size());
      end
   endtask

   task automatic test_flush();
      begin_test(0);
      for (int c = 0; c < 3; c++) step(1'b1, 24'(32 + c), 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_lvl !== 3'd3) begin
         errors++; $display("FAIL flush_pre got=%0d want=3", o_lvl);
      end
      step(1'b1, 24'hEEEEEE, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (o_lvl !== 3'd0 || o_vld !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty k=%0d got lvl=%0d vld=%b rdy=%b want 0/0/1",
                     k, o_lvl, o_vld, o_rdy);
         end
         checks++;
         if (o_ce !== logic'(k % 4 == 3)) begin
            errors++; $display("FAIL flush_ce k=%0d got=%b want=%b", k, o_ce, k % 4 == 3);
         end
         step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_random(input int s);
      begin_test(s);
      for (int c = 0; c < 300; c++) begin
         checks++;
         if (o_ce !== exp_ce() || o_vld !== logic'(mq.size() > 0) ||
             o_rdy !== logic'(mq.size() < DEPTH) || o_lvl !== 3'(mq.size())) begin
            errors++;
            $display("FAIL rand_ctl sel=%0d c=%0d got ce=%b vld=%b rdy=%b lvl=%0d want %b/%b/%b/%0d",
                     s, c, o_ce, o_vld, o_rdy, o_lvl, exp_ce(), mq.size() > 0,
                     mq.size() < DEPTH, mq.size());
         end
         if (mq.size() > 0) begin
            checks++;
            if (o_data !== mq[0].data || o_last !== mq[0].last) begin
               errors++;
               $display("FAIL rand_head sel=%0d c=%0d got=%h/%b want=%h/%b",
                        s, c, o_data, o_last, mq[0].data, mq[0].last);
            end
         end
         step(logic'($urandom_range(0, 3) != 0), 24'($urandom), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 49) == 0));
      end
   endtask

   task automatic test_async_reset();
      begin_test(0);
      for (int c = 0; c < 3; c++) step(1'b1, 24'(64 + c), 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (o_vld !== 1'b0 || o_lvl !== 3'd0 || o_ce !== 1'b0 || o_rdy !== 1'b1 ||
          o_data !== 24'd0 || o_last !== 1'b0) begin
         errors++;
         $display("FAIL areset_out got vld=%b lvl=%0d ce=%b rdy=%b data=%h last=%b",
                  o_vld, o_lvl, o_ce, o_rdy, o_data, o_last);
      end
      @(negedge pclk);
      rst_n = 1'b1;
      mq.delete();
      popped.delete();
      pop_ph.delete();
      ph = 0;
      step(1'b1, 24'hAAAAAA, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 10 && popped.size() == 0; c++) begin
         checks++;
         if (o_data !== 24'hAAAAAA || o_vld !== 1'b1) begin
            errors++; $display("FAIL areset_head c=%0d got=%h/%b want=aaaaaa/1", c, o_data, o_vld);
         end
         step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (popped.size() != 1 || pop_ph[0] != 3 || o_vld !== 1'b0) begin
         errors++;
         $display("FAIL areset_pop got pops=%0d vld=%b want pops=1 at ph 3 vld=0",
                  popped.size(), o_vld);
      end
   endtask

   initial begin
      repeat (2) @(negedge pclk);
      test_reset();
      test_burst();
      test_div1();
      test_hold();
      test_flush();
      test_random(0);
      test_random(2);
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
